// File: rtl/byte_striping_rx_if.sv
// Handshake bundle for the 4-lane to byte un-striper: upstream word side
// (valid_in/data_inN/ready_out) and downstream byte side (valid_out/data_out/ready_in).
interface byte_striping_rx_if #(
   parameter int WIDTH = 8
);
   logic             valid_in;
   logic [WIDTH-1:0] data_in0;
   logic [WIDTH-1:0] data_in1;
   logic [WIDTH-1:0] data_in2;
   logic [WIDTH-1:0] data_in3;
   logic             ready_out;
   logic             ready_in;
   logic             valid_out;
   logic [WIDTH-1:0] data_out;
   logic [1:0]       lane_idx;

   // master: lane deskew stage plus byte consumer; slave: the un-striper
   modport master (
      output valid_in, data_in0, data_in1, data_in2, data_in3, ready_in,
      input  ready_out, valid_out, data_out, lane_idx
   );

   modport slave (
      input  valid_in, data_in0, data_in1, data_in2, data_in3, ready_in,
      output ready_out, valid_out, data_out, lane_idx
   );
endinterface

// File: rtl/byte_striping_rx.sv
// Receive-side byte un-striper: latches one 4-lane word per accept and replays
// its bytes in lane order 0..3, one per transfer, with no bubble between words.
module byte_striping_rx #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                reset,
   byte_striping_rx_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LANE0 = 3'd1,
      LANE1 = 3'd2,
      LANE2 = 3'd3,
      LANE3 = 3'd4
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] word_reg [4];
   logic [WIDTH-1:0] lane_in  [4];
   logic             load;

   assign lane_in[0] = bus.data_in0;
   assign lane_in[1] = bus.data_in1;
   assign lane_in[2] = bus.data_in2;
   assign lane_in[3] = bus.data_in3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // The holding word only changes on an accepted upstream handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            word_reg[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < 4; i++) begin
            word_reg[i] <= lane_in[i];
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      load          = 1'b0;
      bus.ready_out = 1'b0;
      bus.valid_out = 1'b0;
      bus.data_out  = '0;
      bus.lane_idx  = 2'd0;
      case (state_reg)
         IDLE: begin
            bus.ready_out = 1'b1;
            if (bus.valid_in) begin
               load       = 1'b1;
               state_next = LANE0;
            end
         end
         LANE0: begin
            bus.valid_out = 1'b1;
            bus.data_out  = word_reg[0];
            bus.lane_idx  = 2'd0;
            if (bus.ready_in) state_next = LANE1;
         end
         LANE1: begin
            bus.valid_out = 1'b1;
            bus.data_out  = word_reg[1];
            bus.lane_idx  = 2'd1;
            if (bus.ready_in) state_next = LANE2;
         end
         LANE2: begin
            bus.valid_out = 1'b1;
            bus.data_out  = word_reg[2];
            bus.lane_idx  = 2'd2;
            if (bus.ready_in) state_next = LANE3;
         end
         LANE3: begin
            // Last byte leaving frees the register, so the next word may land on the same edge.
            bus.valid_out = 1'b1;
            bus.data_out  = word_reg[3];
            bus.lane_idx  = 2'd3;
            bus.ready_out = bus.ready_in;
            if (bus.ready_in) begin
               if (bus.valid_in) begin
                  load       = 1'b1;
                  state_next = LANE0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_byte_striping_rx.sv
// Bench for byte_striping_rx: directed scenarios plus a random soak scored
// against a queue model of the flattened byte stream.
module tb_byte_striping_rx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   byte_striping_rx_if #(.WIDTH(8)) bus ();

   byte_striping_rx #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      bus.data_in0 = b0;
      bus.data_in1 = b1;
      bus.data_in2 = b2;
      bus.data_in3 = b3;
   endtask

   task automatic test_reset();
      logic [7:0] w [4];
      #2;
      n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %0b want 0", bus.valid_out); end
      n_cmp++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %02h want 00", bus.data_out); end
      n_cmp++; if (bus.lane_idx !== 2'd0) begin n_fail++; $display("FAIL reset_lane_idx: got %0d want 0", bus.lane_idx); end
      n_cmp++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready_out: got %0b want 1", bus.ready_out); end
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      set_word(w[0], w[1], w[2], w[3]);
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      tick(); tick();
      @(negedge clk);
      n_cmp++; if (bus.data_out !== w[2] || bus.lane_idx !== 2'd2) begin n_fail++; $display("FAIL pre_reset_lane2: got %02h/%0d want %02h/2", bus.data_out, bus.lane_idx, w[2]); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL midreset_valid_out: got %0b want 0", bus.valid_out); end
      n_cmp++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL midreset_data_out: got %02h want 00", bus.data_out); end
      n_cmp++; if (bus.lane_idx !== 2'd0) begin n_fail++; $display("FAIL midreset_lane_idx: got %0d want 0", bus.lane_idx); end
      n_cmp++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL midreset_ready_out: got %0b want 1", bus.ready_out); end
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got valid %0b ready %0b want 0/1", bus.valid_out, bus.ready_out); end
      tick();
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      set_word(w[0], w[1], w[2], w[3]);
      bus.valid_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[0] || bus.lane_idx !== 2'd0) begin n_fail++; $display("FAIL post_reset_first_byte: got %0b/%02h/%0d want 1/%02h/0", bus.valid_out, bus.data_out, bus.lane_idx, w[0]); end
      tick(); tick(); tick(); tick();
      $display("test_reset: mid-word reset discarded word, restart at lane 0");
   endtask

   task automatic test_single_word();
      logic [7:0] exp_b [4];
      exp_b[0] = 8'hA0; exp_b[1] = 8'hB1; exp_b[2] = 8'hC2; exp_b[3] = 8'hD3;
      set_word(8'hA0, 8'hB1, 8'hC2, 8'hD3);
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_idle: got ready %0b valid %0b want 1/0", bus.ready_out, bus.valid_out); end
      tick();
      bus.valid_in = 1'b0;
      set_word(8'h5A, 8'h5A, 8'h5A, 8'h5A);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== exp_b[k] || bus.lane_idx !== 2'(k)) begin n_fail++; $display("FAIL single_byte%0d: got %0b/%02h/%0d want 1/%02h/%0d", k, bus.valid_out, bus.data_out, bus.lane_idx, exp_b[k], k); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %0b want 0", bus.valid_out); end
      tick();
      $display("test_single_word: word A0 B1 C2 D3 delivered");
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      set_word(8'h10, 8'h11, 8'h12, 8'h13);
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b1;
      tick();
      set_word(8'h20, 8'h21, 8'h22, 8'h23);
      for (int i = 0; i < 8; i++) begin
         e = ((i < 4) ? 8'h10 : 8'h20) + 8'(i % 4);
         @(negedge clk);
         n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== e || bus.lane_idx !== 2'(i % 4)) begin n_fail++; $display("FAIL b2b_byte%0d: got %0b/%02h/%0d want 1/%02h/%0d", i, bus.valid_out, bus.data_out, bus.lane_idx, e, i % 4); end
         if (i < 3) begin
            n_cmp++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL b2b_ready%0d: got %0b want 0", i, bus.ready_out); end
         end else if (i == 3) begin
            n_cmp++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL b2b_lane3_ready: got %0b want 1", bus.ready_out); end
         end
         tick();
         if (i == 3) bus.valid_in = 1'b0;
      end
      @(negedge clk);
      n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %0b want 0", bus.valid_out); end
      tick();
      $display("test_back_to_back: words 10..13 and 20..23 delivered contiguously");
   endtask

   task automatic test_stall_lane1();
      logic [7:0] w [4];
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      set_word(w[0], w[1], w[2], w[3]);
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.data_out !== w[0] || bus.lane_idx !== 2'd0) begin n_fail++; $display("FAIL stall1_lane0: got %02h/%0d want %02h/0", bus.data_out, bus.lane_idx, w[0]); end
      tick();
      bus.ready_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[1] || bus.lane_idx !== 2'd1 || bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL stall1_hold%0d: got %0b/%02h/%0d rdy %0b want 1/%02h/1 rdy 0", c, bus.valid_out, bus.data_out, bus.lane_idx, bus.ready_out, w[1]); end
         tick();
      end
      bus.ready_in = 1'b1;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[k] || bus.lane_idx !== 2'(k)) begin n_fail++; $display("FAIL stall1_resume%0d: got %0b/%02h/%0d want 1/%02h/%0d", k, bus.valid_out, bus.data_out, bus.lane_idx, w[k], k); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL stall1_end_valid: got %0b want 0", bus.valid_out); end
      tick();
      $display("test_stall_lane1: word held 3 cycles in lane 1, delivered intact");
   endtask

   task automatic test_stall_lane3();
      logic [7:0] w1 [4];
      logic [7:0] w2 [4];
      for (int i = 0; i < 4; i++) begin
         w1[i] = 8'($urandom);
         w2[i] = 8'($urandom);
      end
      set_word(w1[0], w1[1], w1[2], w1[3]);
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      tick(); tick(); tick();
      bus.ready_in = 1'b0;
      bus.valid_in = 1'b1;
      set_word(8'(~w2[0]), 8'(~w2[1]), 8'(~w2[2]), 8'(~w2[3]));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++; if (bus.ready_out !== 1'b0 || bus.data_out !== w1[3] || bus.lane_idx !== 2'd3 || bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL stall3_hold%0d: got rdy %0b %0b/%02h/%0d want rdy 0 1/%02h/3", c, bus.ready_out, bus.valid_out, bus.data_out, bus.lane_idx, w1[3]); end
         tick();
         set_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      set_word(w2[0], w2[1], w2[2], w2[3]);
      bus.ready_in = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL stall3_release_ready: got %0b want 1", bus.ready_out); end
      tick();
      bus.valid_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w2[k] || bus.lane_idx !== 2'(k)) begin n_fail++; $display("FAIL stall3_new%0d: got %0b/%02h/%0d want 1/%02h/%0d", k, bus.valid_out, bus.data_out, bus.lane_idx, w2[k], k); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL stall3_end_valid: got %0b want 0", bus.valid_out); end
      tick();
      $display("test_stall_lane3: stalled lane 3 held off the next word until release");
   endtask

   task automatic test_random_soak();
      logic [7:0] q [$];
      int         words_in = 0;
      int         words_done = 0;
      int         cyc = 0;
      bit         exp_valid;
      bit         exp_ready;
      bit         prev_stall = 1'b0;
      logic [7:0] exp_lane;
      while (words_done < 1000 && cyc < 30000) begin
         bus.valid_in = (words_in < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
         bus.ready_in = ($urandom_range(0, 3) != 0);
         set_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         @(negedge clk);
         // Model: bytes still owed from the current word, in lane order.
         exp_valid = (q.size() != 0);
         exp_ready = (q.size() == 0) || (q.size() == 1 && bus.ready_in);
         n_cmp++; if (bus.valid_out !== exp_valid) begin n_fail++; $display("FAIL soak_valid c%0d: got %0b want %0b", cyc, bus.valid_out, exp_valid); end
         n_cmp++; if (bus.ready_out !== exp_ready) begin n_fail++; $display("FAIL soak_ready c%0d: got %0b want %0b", cyc, bus.ready_out, exp_ready); end
         if (prev_stall) begin
            n_cmp++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL soak_retract c%0d: got valid %0b want 1", cyc, bus.valid_out); end
         end
         if (exp_valid) begin
            exp_lane = 8'(4 - q.size());
            n_cmp++; if (bus.data_out !== q[0] || {6'd0, bus.lane_idx} !== exp_lane) begin n_fail++; $display("FAIL soak_data c%0d: got %02h/%0d want %02h/%0d", cyc, bus.data_out, bus.lane_idx, q[0], exp_lane); end
         end
         prev_stall = bus.valid_out & ~bus.ready_in;
         @(posedge clk);
         if (exp_valid && bus.ready_in) begin
            if (q.size() == 1) begin
               $display("soak word %0d delivered", words_done);
               words_done++;
            end
            void'(q.pop_front());
         end
         if (bus.valid_in && exp_ready) begin
            q.push_back(bus.data_in0);
            q.push_back(bus.data_in1);
            q.push_back(bus.data_in2);
            q.push_back(bus.data_in3);
            words_in++;
         end
         #1;
         cyc++;
      end
      bus.valid_in = 1'b0;
      n_cmp++; if (words_done != 1000) begin n_fail++; $display("FAIL soak_timeout: got %0d words want 1000", words_done); end
      @(negedge clk);
      n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL soak_drain_valid: got %0b want 0", bus.valid_out); end
      tick();
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b0;
      set_word(8'h00, 8'h00, 8'h00, 8'h00);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall_lane1();
      test_stall_lane3();
      test_random_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
